// File: rtl/rr_replay_bus_unpacker_pkg.sv
// rtl/rr_replay_bus_unpacker_pkg.sv - shared channel-width constants and fixed-offset helper
package rr_replay_bus_unpacker_pkg;

    localparam int RR_CHANNEL_WIDTH_BITS = 8;
    localparam int RR_MAX_CHANNELS       = 16;
    localparam int RR_LOGB_CHANNEL_CNT   = 4;
    localparam int RR_LOGE_CHANNEL_CNT   = 1;

    localparam bit [RR_LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] RR_DEFAULT_WIDTHS =
        {8'd32, 8'd4, 8'd16, 8'd8};

    // Width tables are zero-extended to this size so one helper serves any channel count.
    typedef bit [RR_MAX_CHANNELS-1:0][RR_CHANNEL_WIDTH_BITS-1:0] rr_width_tbl_t;

    function automatic int rr_fixed_offset(input rr_width_tbl_t widths, input int idx);
        int sum;
        sum = 0;
        for (int j = 0; j < idx; j++) begin
            sum += int'(widths[j]);
        end
        return sum;
    endfunction

endpackage

// File: rtl/rr_replay_bus_unpacker_offset_calc.sv
// rtl/rr_replay_bus_unpacker_offset_calc.sv - rr_unpack_offset_calc: packed prefix offsets from valid bits
module rr_unpack_offset_calc
    import rr_replay_bus_unpacker_pkg::*;
#(
    parameter int LOGB_CHANNEL_CNT = RR_LOGB_CHANNEL_CNT,
    parameter int LEN_WIDTH        = 6,
    parameter bit [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS = RR_DEFAULT_WIDTHS
) (
    input  logic [LOGB_CHANNEL_CNT-1:0]                i_logb_valid,
    output logic [LOGB_CHANNEL_CNT-1:0][LEN_WIDTH-1:0] o_off,
    output logic [LEN_WIDTH-1:0]                       o_total
);

    logic [LEN_WIDTH-1:0] w_acc;

    always_comb begin
        w_acc = '0;
        for (int i = 0; i < LOGB_CHANNEL_CNT; i++) begin
            o_off[i] = w_acc;
            if (i_logb_valid[i]) begin
                w_acc = w_acc + LEN_WIDTH'(CHANNEL_WIDTHS[i]);
            end
        end
        o_total = w_acc;
    end

endmodule

// File: rtl/rr_replay_bus_unpacker.sv
// rtl/rr_replay_bus_unpacker.sv - two-stage logb unpacker; RR_UNPACK_LEN_CHECK_EN adds length check
module rr_replay_bus_unpacker
    import rr_replay_bus_unpacker_pkg::*;
#(
    parameter int LOGB_CHANNEL_CNT = RR_LOGB_CHANNEL_CNT,
    parameter int LOGE_CHANNEL_CNT = RR_LOGE_CHANNEL_CNT,
    parameter bit [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS = RR_DEFAULT_WIDTHS,
    localparam rr_width_tbl_t W_TBL =
        (RR_MAX_CHANNELS*RR_CHANNEL_WIDTH_BITS)'(CHANNEL_WIDTHS),
    localparam int FULL_WIDTH = rr_fixed_offset(W_TBL, LOGB_CHANNEL_CNT),
    localparam int LEN_WIDTH  = $clog2(FULL_WIDTH+1)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        in_valid,
    input  logic [LOGB_CHANNEL_CNT-1:0] in_logb_valid,
    input  logic [LOGE_CHANNEL_CNT-1:0] in_loge_valid,
    input  logic [FULL_WIDTH-1:0]       in_data,
    input  logic [LEN_WIDTH-1:0]        in_len,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [LOGB_CHANNEL_CNT-1:0] out_logb_valid,
    output logic [LOGE_CHANNEL_CNT-1:0] out_loge_valid,
    output logic [FULL_WIDTH-1:0]       out_data,
    input  logic                        out_ready,
    output logic                        len_err,
    output logic [15:0]                 len_err_cnt
);

    logic                                        w_s1_en, w_s2_en;
    logic [LOGB_CHANNEL_CNT-1:0][LEN_WIDTH-1:0]  w_off;
    logic [LEN_WIDTH-1:0]                        w_total;
    logic [FULL_WIDTH-1:0]                       w_unpacked;

    logic                                        r_s1_v, r_s2_v;
    logic [FULL_WIDTH-1:0]                       r_s1_data, r_s2_data;
    logic [LOGB_CHANNEL_CNT-1:0]                 r_s1_logb, r_s2_logb;
    logic [LOGE_CHANNEL_CNT-1:0]                 r_s1_loge, r_s2_loge;
    logic [LOGB_CHANNEL_CNT-1:0][LEN_WIDTH-1:0]  r_s1_off;

    rr_unpack_offset_calc #(
        .LOGB_CHANNEL_CNT (LOGB_CHANNEL_CNT),
        .LEN_WIDTH        (LEN_WIDTH),
        .CHANNEL_WIDTHS   (CHANNEL_WIDTHS)
    ) u_offset_calc (
        .i_logb_valid (in_logb_valid),
        .o_off        (w_off),
        .o_total      (w_total)
    );

    assign w_s2_en  = !r_s2_v || out_ready;
    assign w_s1_en  = !r_s1_v || w_s2_en;
    assign in_ready = w_s1_en;

    // Each channel only picks its own W bits, so packed bits past the total never reach the bus.
    for (genvar g = 0; g < LOGB_CHANNEL_CNT; g++) begin : g_scatter
        localparam int W   = int'(CHANNEL_WIDTHS[g]);
        localparam int OFF = rr_fixed_offset(W_TBL, g);
        logic [W-1:0] w_slice;
        assign w_slice = W'(r_s1_data >> r_s1_off[g]);
        assign w_unpacked[OFF +: W] = r_s1_logb[g] ? w_slice : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_v    <= 1'b0;
            r_s1_data <= '0;
            r_s1_logb <= '0;
            r_s1_loge <= '0;
            r_s1_off  <= '0;
            r_s2_v    <= 1'b0;
            r_s2_data <= '0;
            r_s2_logb <= '0;
            r_s2_loge <= '0;
        end else begin
            if (w_s1_en) begin
                r_s1_v <= in_valid;
                if (in_valid) begin
                    r_s1_data <= in_data;
                    r_s1_logb <= in_logb_valid;
                    r_s1_loge <= in_loge_valid;
                    r_s1_off  <= w_off;
                end
            end
            if (w_s2_en) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_s2_data <= w_unpacked;
                    r_s2_logb <= r_s1_logb;
                    r_s2_loge <= r_s1_loge;
                end
            end
        end
    end

    assign out_valid      = r_s2_v;
    assign out_data       = r_s2_data;
    assign out_logb_valid = r_s2_logb;
    assign out_loge_valid = r_s2_loge;

`ifdef RR_UNPACK_LEN_CHECK_EN
    logic [LEN_WIDTH-1:0] r_s1_len, r_s1_total;
    logic                 r_len_err;
    logic [15:0]          r_len_err_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_len      <= '0;
            r_s1_total    <= '0;
            r_len_err     <= 1'b0;
            r_len_err_cnt <= '0;
        end else begin
            if (w_s1_en && in_valid) begin
                r_s1_len   <= in_len;
                r_s1_total <= w_total;
            end
            if (r_s1_v && w_s2_en && (r_s1_total != r_s1_len)) begin
                r_len_err <= 1'b1;
                if (r_len_err_cnt != 16'hFFFF) begin
                    r_len_err_cnt <= r_len_err_cnt + 16'd1;
                end
            end
        end
    end

    assign len_err     = r_len_err;
    assign len_err_cnt = r_len_err_cnt;
`else
    logic w_unused_len;
    assign w_unused_len = ^{w_total, in_len};
    assign len_err      = 1'b0;
    assign len_err_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_rr_replay_bus_unpacker.sv
// tb/tb_rr_replay_bus_unpacker.sv - randomized self-checking bench for rr_replay_bus_unpacker
module tb_rr_replay_bus_unpacker;

    localparam int FW = 60;
    localparam int LW = 6;

`ifdef RR_UNPACK_LEN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0;
    logic [3:0]    in_logb_valid = '0;
    logic [0:0]    in_loge_valid = '0;
    logic [FW-1:0] in_data = '0;
    logic [LW-1:0] in_len = '0;
    logic          in_ready;
    logic          out_valid;
    logic [3:0]    out_logb_valid;
    logic [0:0]    out_loge_valid;
    logic [FW-1:0] out_data;
    logic          out_ready = 1'b1;
    logic          len_err;
    logic [15:0]   len_err_cnt;

    rr_replay_bus_unpacker dut (
        .clk            (clk),
        .rstn           (rstn),
        .in_valid       (in_valid),
        .in_logb_valid  (in_logb_valid),
        .in_loge_valid  (in_loge_valid),
        .in_data        (in_data),
        .in_len         (in_len),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_logb_valid (out_logb_valid),
        .out_loge_valid (out_loge_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .len_err        (len_err),
        .len_err_cnt    (len_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] d;
        logic [3:0]    lb;
        logic [0:0]    le;
        int            cnt;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    int    model_cnt = 0;
    int    W[4] = '{8, 16, 4, 32};
    beat_t exp_q[$];

    // Reference: walk the packed stream bit by bit, dropping each present channel at its home slot.
    function automatic logic [FW-1:0] model_unpack(input logic [3:0] v, input logic [FW-1:0] d);
        logic [FW-1:0] r;
        int src, dst;
        r = '0; src = 0; dst = 0;
        for (int c = 0; c < 4; c++) begin
            if (v[c]) begin
                for (int b = 0; b < W[c]; b++) r[dst+b] = d[src+b];
                src += W[c];
            end
            dst += W[c];
        end
        return r;
    endfunction

    function automatic int model_total(input logic [3:0] v);
        int t;
        t = 0;
        for (int c = 0; c < 4; c++) if (v[c]) t += W[c];
        return t;
    endfunction

    function automatic logic [FW-1:0] rand_data();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[FW-1:0];
    endfunction

    task automatic push_model(input logic [3:0] v, input logic [0:0] le,
                              input logic [FW-1:0] d, input logic [LW-1:0] len);
        beat_t e;
        if (CHK && (model_total(v) != int'(len)) && model_cnt < 65535) model_cnt++;
        e.d = model_unpack(v, d);
        e.lb = v;
        e.le = le;
        e.cnt = CHK ? model_cnt : 0;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [3:0] v, input logic [0:0] le,
                         input logic [FW-1:0] d, input logic [LW-1:0] len);
        in_valid = 1'b1;
        in_logb_valid = v;
        in_loge_valid = le;
        in_data = d;
        in_len = len;
    endtask

    // Presents one beat with an empty pipeline; returns after the accepting edge.
    task automatic send_one(input logic [3:0] v, input logic [0:0] le,
                            input logic [FW-1:0] d, input logic [LW-1:0] len);
        @(negedge clk);
        out_ready = 1'b1;
        drive(v, le, d, len);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_in_ready got %b want 1", in_ready);
        end
        push_model(v, le, d, len);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = rand_data();
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 10);
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (out_data !== '0 || out_logb_valid !== 4'b0 || out_loge_valid !== 1'b0 ||
            len_err !== 1'b0 || len_err_cnt !== 16'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got data=%h lb=%b le=%b err=%b cnt=%0d want all 0",
                     out_data, out_logb_valid, out_loge_valid, len_err, len_err_cnt);
        end
    endtask

    task automatic test_all_valid;
        beat_t e;
        int lat;
        logic [FW-1:0] d;
        for (int k = 0; k < 3; k++) begin
            d = rand_data();
            send_one(4'b1111, 1'(k), d, 6'd60);
            wait_out(lat);
            checks++;
            if (lat != 2) begin
                errors++;
                $display("FAIL all_valid_latency got %0d want 2", lat);
            end
            e = exp_q.pop_front();
            checks++;
            if (out_data !== d || out_data !== e.d || out_logb_valid !== 4'b1111 || out_loge_valid !== e.le) begin
                errors++;
                $display("FAIL all_valid_data got %h lb=%b le=%b want %h lb=1111 le=%b",
                         out_data, out_logb_valid, out_loge_valid, d, e.le);
            end
            checks++;
            if (len_err !== 1'b0) begin
                errors++;
                $display("FAIL all_valid_len_err got %b want 0", len_err);
            end
        end
    endtask

    task automatic test_sparse;
        beat_t e;
        int lat;
        logic [FW-1:0] d, want;
        d = rand_data();
        d[15:0] = 16'hBEEF;
        d[47:16] = 32'hDEADC0DE;
        want = '0;
        want[23:8] = 16'hBEEF;
        want[59:28] = 32'hDEADC0DE;
        send_one(4'b1010, 1'b0, d, 6'd48);
        wait_out(lat);
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== want || out_data !== e.d || out_logb_valid !== 4'b1010) begin
            errors++;
            $display("FAIL sparse_1010 got v=%b %h lb=%b want v=1 %h lb=1010",
                     out_valid, out_data, out_logb_valid, want);
        end
    endtask

    task automatic test_loge_only;
        beat_t e;
        int lat;
        send_one(4'b0000, 1'b1, rand_data(), 6'd0);
        wait_out(lat);
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== '0 || out_loge_valid !== 1'b1 || out_logb_valid !== 4'b0) begin
            errors++;
            $display("FAIL loge_only got v=%b %h le=%b lb=%b want v=1 0 le=1 lb=0",
                     out_valid, out_data, out_loge_valid, out_logb_valid);
        end
    endtask

    task automatic test_backpressure;
        beat_t e;
        logic [FW-1:0] d[4];
        logic [3:0]    v[4];
        int acc, got, cyc;
        acc = 0; got = 0; cyc = 0;
        for (int i = 0; i < 4; i++) begin
            d[i] = rand_data();
            v[i] = 4'($urandom());
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            drive(v[acc], 1'(acc), d[acc], LW'(model_total(v[acc])));
            #1;
            if (in_ready) begin
                push_model(v[acc], 1'(acc), d[acc], LW'(model_total(v[acc])));
                acc++;
            end
        end
        checks++;
        if (acc != 2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept_count got acc=%0d ready=%b want acc=2 ready=0", acc, in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_q[0].d) begin
            errors++;
            $display("FAIL bp_stall_hold got v=%b %h want v=1 %h", out_valid, out_data, exp_q[0].d);
        end
        while (got < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            out_ready = 1'b1;
            if (acc < 4) drive(v[acc], 1'(acc), d[acc], LW'(model_total(v[acc])));
            else in_valid = 1'b0;
            #1;
            if (out_valid) begin
                e = exp_q.pop_front();
                got++;
                checks++;
                if (out_data !== e.d || out_logb_valid !== e.lb || out_loge_valid !== e.le) begin
                    errors++;
                    $display("FAIL bp_order got %h lb=%b le=%b want %h lb=%b le=%b",
                             out_data, out_logb_valid, out_loge_valid, e.d, e.lb, e.le);
                end
            end
            if (in_valid && in_ready) begin
                push_model(v[acc], 1'(acc), d[acc], LW'(model_total(v[acc])));
                acc++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL bp_drain_timeout got %0d beats want 4", got);
        end
    endtask

    task automatic test_len_check;
        beat_t e;
        int lat;
        send_one(4'b0001, 1'b0, rand_data(), 6'd9);
        wait_out(lat);
        e = exp_q.pop_front();
        checks++;
        if (len_err !== (CHK ? 1'b1 : 1'b0) || len_err_cnt !== 16'(e.cnt)) begin
            errors++;
            $display("FAIL len_mismatch got err=%b cnt=%0d want err=%b cnt=%0d",
                     len_err, len_err_cnt, CHK, e.cnt);
        end
        send_one(4'b0001, 1'b0, rand_data(), 6'd8);
        wait_out(lat);
        e = exp_q.pop_front();
        checks++;
        if (len_err !== (CHK ? 1'b1 : 1'b0) || len_err_cnt !== 16'(e.cnt) || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL len_good_after got err=%b cnt=%0d want err=%b cnt=%0d",
                     len_err, len_err_cnt, CHK, e.cnt);
        end
    endtask

    task automatic test_random_stream;
        beat_t e;
        logic [3:0]    v;
        logic [0:0]    le;
        logic [FW-1:0] d;
        logic [LW-1:0] len;
        int cyc;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            v = 4'($urandom());
            le = 1'($urandom());
            d = rand_data();
            len = LW'(model_total(v));
            if ($urandom_range(0, 7) == 0) len = LW'(model_total(v) + 1 + $urandom_range(0, 4));
            if ($urandom_range(0, 9) < 7) drive(v, le, d, len);
            else in_valid = 1'b0;
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_extra_beat got %h want no beat", out_data);
                end else begin
                    e = exp_q[0];
                    checks++;
                    if (out_data !== e.d || out_logb_valid !== e.lb || out_loge_valid !== e.le) begin
                        errors++;
                        $display("FAIL rand_beat got %h lb=%b le=%b want %h lb=%b le=%b",
                                 out_data, out_logb_valid, out_loge_valid, e.d, e.lb, e.le);
                    end
                    checks++;
                    if (len_err_cnt !== 16'(e.cnt) || len_err !== (e.cnt != 0)) begin
                        errors++;
                        $display("FAIL rand_len_cnt got err=%b cnt=%0d want cnt=%0d",
                                 len_err, len_err_cnt, e.cnt);
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) push_model(v, le, d, len);
        end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            in_valid = 1'b0;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                e = exp_q.pop_front();
                checks++;
                if (out_data !== e.d || out_logb_valid !== e.lb || out_loge_valid !== e.le) begin
                    errors++;
                    $display("FAIL rand_drain got %h want %h", out_data, e.d);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_lost_beats got %0d outstanding want 0", exp_q.size());
        end
    endtask

    task automatic test_async_reset;
        int seen;
        seen = 0;
        @(negedge clk);
        out_ready = 1'b0;
        drive(4'b1111, 1'b1, rand_data(), 6'd60);
        @(negedge clk);
        drive(4'b0011, 1'b0, rand_data(), 6'd24);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL areset_prefill got v=%b ready=%b want v=1 ready=0", out_valid, in_ready);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
            errors++;
            $display("FAIL areset_immediate got v=%b ready=%b data=%h want v=0 ready=1 data=0",
                     out_valid, in_ready, out_data);
        end
        @(negedge clk);
        rstn = 1'b1;
        model_cnt = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0 || in_ready !== 1'b1 || len_err_cnt !== 16'd0 || len_err !== 1'b0) begin
            errors++;
            $display("FAIL areset_after got stale=%0d ready=%b cnt=%0d want stale=0 ready=1 cnt=0",
                     seen, in_ready, len_err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_all_valid();
        test_sparse();
        test_loge_only();
        test_backpressure();
        test_len_check();
        test_random_stream();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
